// File: rtl/threshold_detector_seq.sv
// Registered popcount threshold detector with hold-off debounce
// and a saturating detection-event counter.
module threshold_detector_seq #(
  parameter  int NBITS = 3,
  parameter  int HOLD  = 2,
  parameter  int CNT_W = 8,
  localparam int PCW   = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_val,
  input  logic [NBITS-1:0] in_,
  input  logic [PCW-1:0]   thresh,
  input  logic             mode,
  output logic             out,
  output logic             rise,
  output logic [PCW-1:0]   count,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int RW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    DETECTED
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [RW-1:0]   run;
  logic [RW-1:0]   run_n;
  logic [RW-1:0]   run_inc;
  logic [PCW-1:0]  pc;
  logic            match;
  logic            enter;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NBITS; i++) begin
      pc = pc + PCW'(in_[i]);
    end
  end

  // thresh above NBITS can never be reached by pc, so no extra guard
  assign match   = mode ? (pc == thresh) : (pc >= thresh);
  assign run_inc = run + RW'(1);

  always_comb begin
    state_n = state;
    run_n   = run;
    if (in_val) begin
      case (state)
        IDLE: begin
          if (match) begin
            run_n   = RW'(1);
            state_n = (HOLD == 1) ? DETECTED : ARMING;
          end
        end
        ARMING: begin
          if (match) begin
            run_n = run_inc;
            if (run_inc == RW'(HOLD)) state_n = DETECTED;
          end else begin
            run_n   = '0;
            state_n = IDLE;
          end
        end
        DETECTED: begin
          if (!match) begin
            run_n   = '0;
            state_n = IDLE;
          end
        end
        default: begin
          run_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign enter = (state_n == DETECTED) && (state != DETECTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= '0;
      rise      <= 1'b0;
      count     <= '0;
      event_cnt <= '0;
    end else if (clear) begin
      state     <= IDLE;
      run       <= '0;
      rise      <= 1'b0;
      count     <= '0;
      event_cnt <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
      rise  <= enter;
      if (in_val) count <= pc;
      if (enter && (event_cnt != {CNT_W{1'b1}})) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
    end
  end

  assign out = (state == DETECTED);

endmodule

// File: tb/tb_threshold_detector_seq.sv
// Bench for threshold_detector_seq: HOLD=1 and HOLD=2/CNT_W=2 instances
// driven in parallel and compared against a streak-based reference.
module tb_threshold_detector_seq;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_val;
  logic [2:0] in_;
  logic [1:0] thresh;
  logic       mode;

  logic       out1, rise1, out2, rise2;
  logic [1:0] count1, count2;
  logic [7:0] ev1;
  logic [1:0] ev2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: consecutive matching valid samples per instance
  int m_streak1, m_streak2;
  int m_out1, m_out2, m_rise1, m_rise2;
  int m_ev1, m_ev2, m_cnt;

  threshold_detector_seq #(.NBITS(3), .HOLD(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(in_val),
    .in_(in_), .thresh(thresh), .mode(mode),
    .out(out1), .rise(rise1), .count(count1), .event_cnt(ev1)
  );

  threshold_detector_seq #(.NBITS(3), .HOLD(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(in_val),
    .in_(in_), .thresh(thresh), .mode(mode),
    .out(out2), .rise(rise2), .count(count2), .event_cnt(ev2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_streak1 = 0; m_streak2 = 0;
    m_out1 = 0; m_out2 = 0; m_rise1 = 0; m_rise2 = 0;
    m_ev1 = 0; m_ev2 = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int pc;
    bit hit;
    int o1, o2;
    if (clear) begin
      model_reset();
      return;
    end
    m_rise1 = 0;
    m_rise2 = 0;
    if (!in_val) return;
    pc  = $countones(in_);
    hit = mode ? (pc == int'(thresh)) : (pc >= int'(thresh));
    m_cnt = pc;
    m_streak1 = hit ? m_streak1 + 1 : 0;
    m_streak2 = hit ? m_streak2 + 1 : 0;
    o1 = (m_streak1 >= 1) ? 1 : 0;
    o2 = (m_streak2 >= 2) ? 1 : 0;
    m_rise1 = (o1 == 1 && m_out1 == 0) ? 1 : 0;
    m_rise2 = (o2 == 1 && m_out2 == 0) ? 1 : 0;
    if (m_rise1 == 1 && m_ev1 < 255) m_ev1++;
    if (m_rise2 == 1 && m_ev2 < 3) m_ev2++;
    m_out1 = o1;
    m_out2 = o2;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".out1"},  int'(out1),   m_out1);
    chk({tag, ".rise1"}, int'(rise1),  m_rise1);
    chk({tag, ".cnt1"},  int'(count1), m_cnt);
    chk({tag, ".ev1"},   int'(ev1),    m_ev1);
    chk({tag, ".out2"},  int'(out2),   m_out2);
    chk({tag, ".rise2"}, int'(rise2),  m_rise2);
    chk({tag, ".cnt2"},  int'(count2), m_cnt);
    chk({tag, ".ev2"},   int'(ev2),    m_ev2);
  endtask

  task automatic step(string tag, bit c, bit v, logic [2:0] x,
                      logic [1:0] th, bit md);
    clear  = c;
    in_val = v;
    in_    = x;
    thresh = th;
    mode   = md;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_val = 1'b0;
    in_ = '0; thresh = 2'd2; mode = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // pair/triple sweep
    for (int i = 0; i < 8; i++) begin
      step("sweep", 0, 1, 3'(i), 2'd2, 0);
      chk("sweep.lit", int'(out1), ($countones(3'(i)) >= 2) ? 1 : 0);
    end
    step("flush", 0, 1, 3'b000, 2'd2, 0);

    // hold of two
    step("hold.a", 0, 1, 3'b011, 2'd2, 0);
    step("hold.b", 0, 1, 3'b000, 2'd2, 0);
    step("hold.c", 0, 1, 3'b011, 2'd2, 0);
    chk("hold.c.lit", int'(out2), 0);
    step("hold.d", 0, 1, 3'b011, 2'd2, 0);
    chk("hold.d.lit", int'(rise2), 1);
    step("hold.e", 0, 1, 3'b011, 2'd2, 0);
    chk("hold.e.lit", int'(rise2), 0);

    // exact mode
    step("exact.clr", 1, 0, 3'b000, 2'd2, 1);
    step("exact.a", 0, 1, 3'b111, 2'd2, 1);
    step("exact.b", 0, 1, 3'b110, 2'd2, 1);
    step("exact.c", 0, 1, 3'b110, 2'd2, 1);
    chk("exact.c.lit", int'(out2), 1);
    step("exact.d", 0, 1, 3'b111, 2'd2, 1);
    chk("exact.d.lit", int'(out2), 0);

    // stall keeps state and count
    step("stall.a", 0, 1, 3'b011, 2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall.s", 0, 0, 3'b111, 2'd0, 1);
      chk("stall.cnt", int'(count2), 2);
    end
    step("stall.b", 0, 1, 3'b011, 2'd2, 0);
    chk("stall.b.lit", int'(out2), 1);

    // threshold zero always matches in at-least mode
    step("th0", 0, 1, 3'b000, 2'd0, 0);

    // saturation of the 2-bit counter
    step("sat.clr", 1, 0, 3'b000, 2'd2, 0);
    for (int i = 0; i < 5; i++) begin
      step("sat.a", 0, 1, 3'b011, 2'd2, 0);
      step("sat.b", 0, 1, 3'b011, 2'd2, 0);
      step("sat.c", 0, 1, 3'b000, 2'd2, 0);
    end
    chk("sat.lit", int'(ev2), 3);
    step("clr.a", 0, 1, 3'b011, 2'd2, 0);
    step("clr.b", 1, 1, 3'b011, 2'd2, 0);
    chk("clr.lit", int'(rise2) + int'(out1) + int'(ev1), 0);

    // async reset mid-ARMING, then mid-DETECTED
    step("ar.a", 0, 1, 3'b011, 2'd2, 0);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("ar.arm");
    #1 rst_n = 1'b1;
    step("ar.b", 0, 1, 3'b011, 2'd2, 0);
    step("ar.c", 0, 1, 3'b011, 2'd2, 0);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("ar.det");
    #1 rst_n = 1'b1;
    step("ar.d", 0, 1, 3'b011, 2'd2, 0);
    step("ar.e", 0, 1, 3'b011, 2'd2, 0);
    chk("ar.e.lit", int'(out2), 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom),
           2'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
